// File: rtl/pe_array_pkg.sv
// Shared constants, state encoding and helpers for the systolic array sequencer.
package pe_array_pkg;

    localparam int N         = 4;
    localparam int K_MAX     = 32;
    localparam int KW        = $clog2(K_MAX + 1);
    localparam int TW        = KW + 1;
    localparam int RW        = $clog2(N);
    localparam int DRAIN_LEN = N;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        READ
    } state_t;

    function automatic int lane_lsb(input int lane);
        return lane * KW;
    endfunction

    // Requests beyond the buffer depth are clamped rather than rejected.
    function automatic logic [KW-1:0] sat_k_len(input logic [KW-1:0] k);
        return (k > KW'(K_MAX)) ? KW'(K_MAX) : k;
    endfunction

endpackage

// File: rtl/pe_feed_skew.sv
// Per-lane skewed feed window: lane i is live for k_len cycles starting at t = i.
module pe_feed_skew
    import pe_array_pkg::*;
(
    input  logic [TW-1:0]   t,
    input  logic [KW-1:0]   k_len,
    output logic [N-1:0]    feed_en,
    output logic [N*KW-1:0] feed_idx
);

    localparam int UW = TW + 1;

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [TW-1:0] LANE = TW'(i);

        logic [UW-1:0] lane_end;
        logic [TW-1:0] offset;

        // One extra bit keeps k_len + i from wrapping at K_MAX.
        assign lane_end   = UW'(k_len) + UW'(LANE);
        assign offset     = t - LANE;
        assign feed_en[i] = (t >= LANE) && (UW'(t) < lane_end);
        assign feed_idx[lane_lsb(i) +: KW] = feed_en[i] ? offset[KW-1:0] : '0;
    end

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for an N x N systolic MAC array: clear, skewed feed, drain, then
// row-by-row readout under valid/ready.
module pe_array_ctrl
    import pe_array_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [KW-1:0]   i_k_len,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_arr_clr,
    output logic [N-1:0]    o_feed_en,
    output logic [N*KW-1:0] o_feed_idx,
    output logic            o_res_valid,
    output logic [RW-1:0]   o_res_row,
    input  logic            i_res_ready
);

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [KW-1:0]   k_len_q, k_len_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            clr_q, clr_d;
    logic            valid_q, valid_d;
    logic [RW-1:0]   res_row_q, res_row_d;
    logic [N-1:0]    feed_en_q, feed_en_d, skew_en;
    logic [N*KW-1:0] feed_idx_q, feed_idx_d, skew_idx;
    logic [TW-1:0]   feed_last;

    // Last FEED value of t: the final lane finishes k_len + N - 1 cycles in.
    assign feed_last = TW'(k_len_q) + TW'(N - 2);

    // Skew is evaluated on the next counter value so enables register in step with state.
    pe_feed_skew u_skew (
        .t        (cnt_d),
        .k_len    (k_len_q),
        .feed_en  (skew_en),
        .feed_idx (skew_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        k_len_d = k_len_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = CLEAR;
                    k_len_d = sat_k_len(i_k_len);
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = (k_len_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                if (cnt_q == feed_last) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == TW'(DRAIN_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            READ: begin
                // Exit is tested before incrementing, so the row counter never wraps.
                if (i_res_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        clr_d      = (state_d == CLEAR);
        valid_d    = (state_d == READ);
        res_row_d  = valid_d ? row_d : '0;
        feed_en_d  = (state_d == FEED) ? skew_en  : '0;
        feed_idx_d = (state_d == FEED) ? skew_idx : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            k_len_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_q      <= 1'b0;
            valid_q    <= 1'b0;
            res_row_q  <= '0;
            feed_en_q  <= '0;
            feed_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            k_len_q    <= k_len_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clr_q      <= clr_d;
            valid_q    <= valid_d;
            res_row_q  <= res_row_d;
            feed_en_q  <= feed_en_d;
            feed_idx_q <= feed_idx_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_arr_clr   = clr_q;
    assign o_feed_en   = feed_en_q;
    assign o_feed_idx  = feed_idx_q;
    assign o_res_valid = valid_q;
    assign o_res_row   = res_row_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl with a behavioural 4x4 MAC array hung off
// the feed outputs so that readout values can be checked as well as timing.
module tb_pe_array_ctrl;
    import pe_array_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_start;
    logic [KW-1:0]   i_k_len;
    logic            o_busy;
    logic            o_done;
    logic            o_arr_clr;
    logic [N-1:0]    o_feed_en;
    logic [N*KW-1:0] o_feed_idx;
    logic            o_res_valid;
    logic [RW-1:0]   o_res_row;
    logic            i_res_ready;

    pe_array_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_k_len     (i_k_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_arr_clr   (o_arr_clr),
        .o_feed_en   (o_feed_en),
        .o_feed_idx  (o_feed_idx),
        .o_res_valid (o_res_valid),
        .o_res_row   (o_res_row),
        .i_res_ready (i_res_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            clr;
        logic [N-1:0]    en;
        logic [N*KW-1:0] idx;
        logic            valid;
        logic [RW-1:0]   row;
    } outs_t;

    typedef struct {
        logic          start;
        logic [KW-1:0] k;
        logic          ready;
        outs_t         exp;
    } vec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t tbl [17];

    // Operand buffers, PE state and the expected product for the current run.
    int a_mat  [N][K_MAX];
    int b_mat  [K_MAX][N];
    int acc    [N][N];
    int a_pipe [N][N];
    int b_pipe [N][N];
    int exp_c  [N][N];

    function automatic int pe_a_in(input int i, input int j);
        if (j == 0)
            return o_feed_en[i] ? a_mat[i][int'(o_feed_idx[i*KW +: KW])] : 0;
        return a_pipe[i][j-1];
    endfunction

    function automatic int pe_b_in(input int i, input int j);
        if (i == 0)
            return o_feed_en[j] ? b_mat[int'(o_feed_idx[j*KW +: KW])][j] : 0;
        return b_pipe[i-1][j];
    endfunction

    // Behavioural PE grid: data moves right, taps move down, each through one register.
    always @(posedge clk) begin
        if (rst || o_arr_clr) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j]    <= 0;
                    a_pipe[i][j] <= 0;
                    b_pipe[i][j] <= 0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j]    <= acc[i][j] + pe_a_in(i, j) * pe_b_in(i, j);
                    a_pipe[i][j] <= pe_a_in(i, j);
                    b_pipe[i][j] <= pe_b_in(i, j);
                end
        end
    end

    function automatic outs_t mk(input logic busy, input logic done, input logic clr,
                                 input logic [N-1:0] en, input logic [N*KW-1:0] idx,
                                 input logic valid, input logic [RW-1:0] row);
        return {busy, done, clr, en, idx, valid, row};
    endfunction

    function automatic logic [N*KW-1:0] idx4(input int l3, input int l2, input int l1, input int l0);
        return {l3[KW-1:0], l2[KW-1:0], l1[KW-1:0], l0[KW-1:0]};
    endfunction

    function automatic outs_t o_idle();
        return mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endfunction

    function automatic outs_t o_clr();
        return mk(1'b1, 1'b0, 1'b1, '0, '0, 1'b0, '0);
    endfunction

    function automatic outs_t o_feed(input logic [N-1:0] en, input logic [N*KW-1:0] idx);
        return mk(1'b1, 1'b0, 1'b0, en, idx, 1'b0, '0);
    endfunction

    function automatic outs_t o_drain();
        return mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endfunction

    function automatic outs_t o_read(input int r);
        return mk(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, r[RW-1:0]);
    endfunction

    function automatic outs_t o_donep();
        return mk(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    endfunction

    // Drive inputs for the current cycle, then step to 1 time unit after the next edge.
    task automatic applyStimulus(input logic start, input logic [KW-1:0] k, input logic ready);
        i_start     = start;
        i_k_len     = k;
        i_res_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = {o_busy, o_done, o_arr_clr, o_feed_en, o_feed_idx, o_res_valid, o_res_row};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got busy=%b done=%b clr=%b en=%b idx=%h valid=%b row=%0d; want busy=%b done=%b clr=%b en=%b idx=%h valid=%b row=%0d",
                     name, act.busy, act.done, act.clr, act.en, act.idx, act.valid, act.row,
                     exp.busy, exp.done, exp.clr, exp.en, exp.idx, exp.valid, exp.row);
        end
    endtask

    task automatic checkResults(input string name, input int r);
        n_cmp++;
        if (acc[r][0] != exp_c[r][0] || acc[r][1] != exp_c[r][1] ||
            acc[r][2] != exp_c[r][2] || acc[r][3] != exp_c[r][3]) begin
            n_fail++;
            $display("[TB] FAIL %s_row%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", name, r,
                     acc[r][0], acc[r][1], acc[r][2], acc[r][3],
                     exp_c[r][0], exp_c[r][1], exp_c[r][2], exp_c[r][3]);
        end
    endtask

    task automatic computeExpected(input int k_eff);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                exp_c[i][j] = 0;
                for (int k = 0; k < k_eff; k++)
                    exp_c[i][j] += a_mat[i][k] * b_mat[k][j];
            end
    endtask

    task automatic setConstMats(input int a, input int b);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K_MAX; k++) begin
                a_mat[i][k] = a;
                b_mat[k][i] = b;
            end
    endtask

    task automatic setIdentMats();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K_MAX; k++) begin
                a_mat[i][k] = (i == k) ? 1 : 0;
                b_mat[k][i] = (k < N) ? k * N + i + 1 : 0;
            end
    endtask

    // One full run from the CLEAR cycle through the o_done pulse; optionally
    // stalls the consumer for stall_n cycles while row stall_row is presented.
    task automatic checkRun(input bit do_start, input int k_in, input int k_eff,
                            input int stall_row, input int stall_n, input string name);
        logic [N-1:0]    en;
        logic [N*KW-1:0] idx;
        int              feed_len;
        if (do_start)
            applyStimulus(1'b1, KW'(k_in), 1'b1);
        i_start = 1'b0;
        i_k_len = '0;
        computeExpected(k_eff);
        checkOutput({name, "_clear"}, o_clr());
        feed_len = (k_eff == 0) ? 0 : k_eff + N - 1;
        for (int t = 0; t < feed_len; t++) begin
            en  = '0;
            idx = '0;
            for (int l = 0; l < N; l++)
                if (t >= l && t < l + k_eff) begin
                    en[l]             = 1'b1;
                    idx[l*KW +: KW]   = KW'(t - l);
                end
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("%s_feed_t%0d", name, t), o_feed(en, idx));
        end
        for (int d = 0; d < N; d++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("%s_drain%0d", name, d), o_drain());
        end
        applyStimulus(1'b0, '0, 1'b1);
        for (int r = 0; r < N; r++) begin
            checkOutput($sformatf("%s_read%0d", name, r), o_read(r));
            checkResults(name, r);
            if (r == stall_row)
                for (int s = 0; s < stall_n; s++) begin
                    applyStimulus(1'b0, '0, 1'b0);
                    checkOutput($sformatf("%s_hold%0d", name, s), o_read(r));
                end
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput({name, "_done"}, o_donep());
    endtask

    initial begin
        i_start     = 1'b0;
        i_k_len     = '0;
        i_res_ready = 1'b0;

        // Table for a k_len=3 run; row c drives cycle c and checks cycle c+1.
        tbl[0]  = '{1'b1, KW'(3), 1'b0, o_clr()};
        tbl[1]  = '{1'b0, KW'(0), 1'b0, o_feed(4'b0001, idx4(0, 0, 0, 0))};
        tbl[2]  = '{1'b0, KW'(0), 1'b0, o_feed(4'b0011, idx4(0, 0, 0, 1))};
        tbl[3]  = '{1'b1, KW'(9), 1'b0, o_feed(4'b0111, idx4(0, 0, 1, 2))};
        tbl[4]  = '{1'b1, KW'(0), 1'b0, o_feed(4'b1110, idx4(0, 1, 2, 0))};
        tbl[5]  = '{1'b0, KW'(0), 1'b0, o_feed(4'b1100, idx4(1, 2, 0, 0))};
        tbl[6]  = '{1'b0, KW'(7), 1'b0, o_feed(4'b1000, idx4(2, 0, 0, 0))};
        tbl[7]  = '{1'b0, KW'(0), 1'b0, o_drain()};
        tbl[8]  = '{1'b0, KW'(0), 1'b0, o_drain()};
        tbl[9]  = '{1'b0, KW'(0), 1'b0, o_drain()};
        tbl[10] = '{1'b0, KW'(0), 1'b0, o_drain()};
        tbl[11] = '{1'b0, KW'(0), 1'b1, o_read(0)};
        tbl[12] = '{1'b0, KW'(0), 1'b1, o_read(1)};
        tbl[13] = '{1'b0, KW'(0), 1'b1, o_read(2)};
        tbl[14] = '{1'b0, KW'(0), 1'b1, o_read(3)};
        tbl[15] = '{1'b0, KW'(0), 1'b1, o_donep()};
        tbl[16] = '{1'b1, KW'(2), 1'b0, o_clr()};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", o_idle());
        rst = 1'b0;
        applyStimulus(1'b0, KW'(17), 1'b0);
        checkOutput("idle_after_reset", o_idle());

        setConstMats(2, 3);
        for (int c = 0; c < 17; c++) begin
            applyStimulus(tbl[c].start, tbl[c].k, tbl[c].ready);
            checkOutput($sformatf("table_c%0d", c + 1), tbl[c].exp);
        end

        // Started from the o_done cycle by the last table row.
        checkRun(1'b0, 2, 2, 1, 3, "k2_stall");
        applyStimulus(1'b0, KW'(5), 1'b1);
        checkOutput("idle_gap", o_idle());

        checkRun(1'b1, 0, 0, -1, 0, "k0");
        checkRun(1'b1, 40, 32, 2, 1, "k40");
        checkRun(1'b1, 3, 3, -1, 0, "k3_const");
        setIdentMats();
        checkRun(1'b1, 4, 4, -1, 0, "k4_ident");
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("idle_after_ident", o_idle());

        // Asynchronous reset in the middle of FEED.
        applyStimulus(1'b1, KW'(5), 1'b1);
        checkOutput("rst_run_clear", o_clr());
        i_start = 1'b0;
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rst_run_feed", o_feed(4'b0111, idx4(0, 0, 1, 2)));
        rst = 1'b1;
        #1;
        checkOutput("rst_async", o_idle());
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, KW'(c), 1'b1);
            checkOutput($sformatf("post_rst_idle%0d", c), o_idle());
        end
        checkRun(1'b1, 2, 2, -1, 0, "k2_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
